// File: rtl/mips_pkg.sv
// Constants shared across MIPS pipeline stages: ALU control codes, ALUOp encodings,
// R-type funct values, and bit positions of the wb/m/ex control vectors.
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // wb = {RegWrite, MemtoReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    // m = {Branch, MemRead, MemWrite}
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;
    // ex = {RegDst, ALUOp[1:0], ALUSrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

endpackage

// File: rtl/alu_control.sv
// Maps ALUOp plus the R-type funct field to the 3-bit ALU operation code.
// Purely combinational; unknown funct and ALUOp 11 both fall back to ADD.
module alu_control
    import mips_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctl_o
);

    always_comb begin
        alu_ctl_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_ctl_o = ALU_ADD;
            ALUOP_SUB: alu_ctl_o = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: alu_ctl_o = ALU_ADD;
                    FUNCT_SUB: alu_ctl_o = ALU_SUB;
                    FUNCT_AND: alu_ctl_o = ALU_AND;
                    FUNCT_OR:  alu_ctl_o = ALU_OR;
                    FUNCT_SLT: alu_ctl_o = ALU_SLT;
                    default:   alu_ctl_o = ALU_ADD;
                endcase
            end
            default: alu_ctl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, destination select and branch target, captured in EX/MEM.
// One-cycle latency; update priority is reset > flush (bubble) > stall (hold) > load.
module ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  id_ex_wb,
    input  logic [2:0]  id_ex_m,
    input  logic [3:0]  id_ex_ex,
    input  logic [31:0] id_ex_npc,
    input  logic [31:0] id_ex_reg1,
    input  logic [31:0] id_ex_reg2,
    input  logic [31:0] id_ex_sign_ext,
    input  logic [4:0]  id_ex_instr20_16,
    input  logic [4:0]  id_ex_instr15_11,
    output logic [1:0]  ex_mem_wb,
    output logic [2:0]  ex_mem_m,
    output logic [31:0] ex_mem_btgt,
    output logic        ex_mem_zero,
    output logic [31:0] ex_mem_alu_result,
    output logic [31:0] ex_mem_rdata2,
    output logic [4:0]  ex_mem_muxout
);

    logic [2:0]  alu_ctl;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] btgt;
    logic [4:0]  dst;

    logic [1:0]  wb_q;
    logic [2:0]  m_q;
    logic [31:0] btgt_q;
    logic        zero_q;
    logic [31:0] alu_res_q;
    logic [31:0] rdata2_q;
    logic [4:0]  muxout_q;

    alu_control u_alu_control (
        .alu_op_i  (id_ex_ex[EX_ALUOP_HI:EX_ALUOP_LO]),
        .funct_i   (id_ex_sign_ext[5:0]),
        .alu_ctl_o (alu_ctl)
    );

    always_comb begin
        op_b = id_ex_ex[EX_ALUSRC] ? id_ex_sign_ext : id_ex_reg2;
        case (alu_ctl)
            ALU_AND: alu_res = id_ex_reg1 & op_b;
            ALU_OR:  alu_res = id_ex_reg1 | op_b;
            ALU_SUB: alu_res = id_ex_reg1 - op_b;
            ALU_SLT: alu_res = ($signed(id_ex_reg1) < $signed(op_b)) ? 32'd1 : 32'd0;
            default: alu_res = id_ex_reg1 + op_b;
        endcase
        btgt = id_ex_npc + (id_ex_sign_ext << 2);
        dst  = id_ex_ex[EX_REGDST] ? id_ex_instr15_11 : id_ex_instr20_16;
    end

    // Flush clears every field, not just the control bits, so a bubble is all-zero.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wb_q      <= '0;
            m_q       <= '0;
            btgt_q    <= '0;
            zero_q    <= 1'b0;
            alu_res_q <= '0;
            rdata2_q  <= '0;
            muxout_q  <= '0;
        end else if (!stall) begin
            wb_q      <= id_ex_wb;
            m_q       <= id_ex_m;
            btgt_q    <= btgt;
            zero_q    <= (alu_res == 32'h0);
            alu_res_q <= alu_res;
            rdata2_q  <= id_ex_reg2;
            muxout_q  <= dst;
        end
    end

    assign ex_mem_wb         = wb_q;
    assign ex_mem_m          = m_q;
    assign ex_mem_btgt       = btgt_q;
    assign ex_mem_zero       = zero_q;
    assign ex_mem_alu_result = alu_res_q;
    assign ex_mem_rdata2     = rdata2_q;
    assign ex_mem_muxout     = muxout_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed test-plan steps against literal results, then random
// stimulus compared every cycle against a behavioural model of the EX/MEM register.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_m;
    logic [3:0]  id_ex_ex;
    logic [31:0] id_ex_npc, id_ex_reg1, id_ex_reg2, id_ex_sign_ext;
    logic [4:0]  id_ex_instr20_16, id_ex_instr15_11;
    logic [1:0]  ex_mem_wb;
    logic [2:0]  ex_mem_m;
    logic [31:0] ex_mem_btgt, ex_mem_alu_result, ex_mem_rdata2;
    logic        ex_mem_zero;
    logic [4:0]  ex_mem_muxout;

    int checks = 0;
    int errors = 0;

    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic [31:0] e_btgt, e_alu, e_rdata2;
    logic        e_zero;
    logic [4:0]  e_mux;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex),
        .id_ex_npc(id_ex_npc), .id_ex_reg1(id_ex_reg1), .id_ex_reg2(id_ex_reg2),
        .id_ex_sign_ext(id_ex_sign_ext),
        .id_ex_instr20_16(id_ex_instr20_16), .id_ex_instr15_11(id_ex_instr15_11),
        .ex_mem_wb(ex_mem_wb), .ex_mem_m(ex_mem_m), .ex_mem_btgt(ex_mem_btgt),
        .ex_mem_zero(ex_mem_zero), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_rdata2(ex_mem_rdata2), .ex_mem_muxout(ex_mem_muxout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU written from the instruction semantics, not the control encoding.
    function automatic logic [31:0] ref_alu(input logic [3:0] ex, input logic [31:0] a,
                                            input logic [31:0] r2, input logic [31:0] se);
        logic [31:0] b;
        int sa, sb;
        b  = ex[0] ? se : r2;
        sa = a;
        sb = b;
        if (ex[2:1] == 2'd1) return a - b;
        if (ex[2:1] == 2'd2) begin
            if (se[5:0] == 6'h22) return a - b;
            if (se[5:0] == 6'h24) return a & b;
            if (se[5:0] == 6'h25) return a | b;
            if (se[5:0] == 6'h2A) return (sa < sb) ? 32'd1 : 32'd0;
        end
        return a + b;
    endfunction

    task automatic model_step();
        logic [31:0] r;
        if (!rst || flush) begin
            e_wb = 0; e_m = 0; e_btgt = 0; e_zero = 0; e_alu = 0; e_rdata2 = 0; e_mux = 0;
        end else if (!stall) begin
            r        = ref_alu(id_ex_ex, id_ex_reg1, id_ex_reg2, id_ex_sign_ext);
            e_wb     = id_ex_wb;
            e_m      = id_ex_m;
            e_btgt   = id_ex_npc + id_ex_sign_ext * 4;
            e_alu    = r;
            e_zero   = (r == 0);
            e_rdata2 = id_ex_reg2;
            e_mux    = id_ex_ex[3] ? id_ex_instr15_11 : id_ex_instr20_16;
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, ".wb"},     32'(ex_mem_wb),     32'(e_wb));
        chk({tag, ".m"},      32'(ex_mem_m),      32'(e_m));
        chk({tag, ".btgt"},   ex_mem_btgt,        e_btgt);
        chk({tag, ".zero"},   32'(ex_mem_zero),   32'(e_zero));
        chk({tag, ".alu"},    ex_mem_alu_result,  e_alu);
        chk({tag, ".rdata2"}, ex_mem_rdata2,      e_rdata2);
        chk({tag, ".muxout"}, 32'(ex_mem_muxout), 32'(e_mux));
    endtask

    task automatic set_in(input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb,
                          input logic [31:0] npc, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] se, input logic [4:0] rt, input logic [4:0] rd);
        id_ex_ex = ex; id_ex_m = m; id_ex_wb = wb; id_ex_npc = npc;
        id_ex_reg1 = r1; id_ex_reg2 = r2; id_ex_sign_ext = se;
        id_ex_instr20_16 = rt; id_ex_instr15_11 = rd;
    endtask

    logic [5:0]  functs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [31:0] rres   [5] = '{32'd12, 32'hFFFFFFFE, 32'd5, 32'd7, 32'd1};

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        set_in(4'hF, 3'h7, 2'h3, 32'h1234, 32'h55, 32'h66, 32'h77, 5'd3, 5'd4);
        tick("reset");
        chk("reset.zero_lit", 32'(ex_mem_zero), 32'd0);
        rst = 1'b1;

        // lw
        set_in(4'b0001, 3'b010, 2'b11, 32'h4, 32'h100, 32'h0, 32'h4, 5'd8, 5'd0);
        tick("lw");
        chk("lw.alu_lit", ex_mem_alu_result, 32'h104);
        chk("lw.mux_lit", 32'(ex_mem_muxout), 32'd8);
        chk("lw.m_lit",   32'(ex_mem_m), 32'b010);

        // R-type
        for (int i = 0; i < 5; i++) begin
            set_in(4'b1100, 3'b000, 2'b10, 32'h8, 32'd5, 32'd7, {26'd0, functs[i]}, 5'd2, 5'd9);
            tick("rtype");
            chk("rtype.alu_lit", ex_mem_alu_result, rres[i]);
            chk("rtype.mux_lit", 32'(ex_mem_muxout), 32'd9);
        end
        set_in(4'b1100, 3'b000, 2'b10, 32'h8, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd2, 5'd9);
        tick("slt_signed");
        chk("slt_signed.alu_lit", ex_mem_alu_result, 32'd1);

        // beq
        set_in(4'b0010, 3'b100, 2'b00, 32'h10000004, 32'd3, 32'd3, 32'd2, 5'd1, 5'd2);
        tick("beq");
        chk("beq.zero_lit", 32'(ex_mem_zero), 32'd1);
        chk("beq.btgt_lit", ex_mem_btgt, 32'h1000000C);
        id_ex_sign_ext = 32'hFFFFFFFF;
        tick("beq_neg");
        chk("beq_neg.btgt_lit", ex_mem_btgt, 32'h10000000);

        // sw
        set_in(4'b0001, 3'b001, 2'b00, 32'h20, 32'h200, 32'hDEADBEEF, 32'h10, 5'd5, 5'd6);
        tick("sw");
        chk("sw.alu_lit",    ex_mem_alu_result, 32'h210);
        chk("sw.rdata2_lit", ex_mem_rdata2, 32'hDEADBEEF);

        // stall holds through changed inputs, then stall+flush bubbles
        set_in(4'b0001, 3'b010, 2'b11, 32'h4, 32'h100, 32'h0, 32'h4, 5'd8, 5'd0);
        tick("stall_load");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(4'b1100, 3'b001, 2'b01, 32'h40 + i, 32'd9 + i, 32'd3, 32'h22, 5'd1, 5'd2);
            tick("stall_hold");
            chk("stall_hold.alu_lit", ex_mem_alu_result, 32'h104);
        end
        flush = 1'b1;
        tick("stall_flush");
        chk("stall_flush.m_lit", 32'(ex_mem_m), 32'd0);
        stall = 1'b0; flush = 1'b0;

        // reset mid-stream beats stall, then first load after release
        set_in(4'b0001, 3'b001, 2'b11, 32'h20, 32'h200, 32'hCAFEF00D, 32'h10, 5'd5, 5'd6);
        tick("pre_rst");
        rst = 1'b0; stall = 1'b1;
        tick("mid_rst");
        chk("mid_rst.rdata2_lit", ex_mem_rdata2, 32'd0);
        rst = 1'b1; stall = 1'b0;
        tick("post_rst");
        chk("post_rst.alu_lit", ex_mem_alu_result, 32'h210);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 19) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            set_in(4'($urandom), 3'($urandom), 2'($urandom), $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                   $urandom,
                   ($urandom_range(0, 1) == 0) ? {$urandom_range(0, 1) == 0 ? 26'h3FFFFFF : 26'd0,
                                                  functs[$urandom_range(0, 4)]} : $urandom,
                   5'($urandom), 5'($urandom));
            if ($urandom_range(0, 5) == 0) id_ex_reg2 = id_ex_reg1;
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline. Consumes the ID/EX pipeline register fields produced by the decode stage, performs ALU control decode, ALU operation, destination-register select and branch-target computation, then captures results in the EX/MEM pipeline register. Supports hazard-unit stall (hold) and flush (bubble insertion).

## Interface
- No parameters; widths fixed at 32-bit datapath, 5-bit register index.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- stall  in  1  hold EX/MEM register contents
- flush  in  1  load a bubble into EX/MEM
- id_ex_wb  in  2  {RegWrite, MemtoReg}
- id_ex_m  in  3  {Branch, MemRead, MemWrite}
- id_ex_ex  in  4  {RegDst, ALUOp[1:0], ALUSrc}
- id_ex_npc  in  32  PC+4 of the instruction
- id_ex_reg1  in  32  rs read data
- id_ex_reg2  in  32  rt read data
- id_ex_sign_ext  in  32  sign-extended immediate; bits [5:0] are funct for R-type
- id_ex_instr20_16  in  5  rt field
- id_ex_instr15_11  in  5  rd field
- ex_mem_wb  out  2  registered id_ex_wb
- ex_mem_m  out  3  registered id_ex_m
- ex_mem_btgt  out  32  branch target
- ex_mem_zero  out  1  ALU result == 0
- ex_mem_alu_result  out  32  ALU result
- ex_mem_rdata2  out  32  registered id_ex_reg2 (store data)
- ex_mem_muxout  out  5  destination register index

## Operation
- ALU control (ALUOp -> 3-bit ctl): 00 -> ADD (010); 01 -> SUB (110); 10 -> decode funct = sign_ext[5:0]: 0x20 ADD, 0x22 SUB, 0x24 AND (000), 0x25 OR (001), 0x2A SLT (111); any other funct -> ADD; ALUOp 11 -> ADD.
- Operand B = ALUSrc ? id_ex_sign_ext : id_ex_reg2; operand A = id_ex_reg1.
- ADD/SUB: 32-bit modulo, no overflow detection or trap. SLT: signed compare, result 1 or 0 zero-extended. AND/OR bitwise.
- zero = (ALU result == 32'h0), computed on the unregistered result, then registered.
- btgt = id_ex_npc + (id_ex_sign_ext << 2), 32-bit modulo; computed every cycle regardless of Branch.
- muxout = RegDst ? id_ex_instr15_11 : id_ex_instr20_16.
- EX/MEM register update priority: reset > flush > stall > normal load.
  - Reset: all outputs 0.
  - Flush: all outputs 0 (RegWrite, MemRead, MemWrite, Branch cleared = bubble).
  - Stall: all outputs hold previous value.
  - Normal: all outputs take the values computed from current ID/EX inputs.

## Timing
- Combinational ALU/control/adder path; single register stage. Latency 1 cycle: inputs valid before edge N appear on outputs after edge N.
- Reset values: ex_mem_wb=2'b00, ex_mem_m=3'b000, ex_mem_btgt=0, ex_mem_zero=0, ex_mem_alu_result=0, ex_mem_rdata2=0, ex_mem_muxout=0. Note zero=0 on reset (not derived from result).
- rst asserted mid-stream: outputs clear at that edge; stall/flush ignored.
- stall and flush asserted together: flush wins.
- Stall held multiple cycles: outputs stable for every stalled cycle; first unstalled edge loads current inputs.
- No handshake beyond stall/flush; block never back-pressures.

## Structure
- Shared package mips_pkg: ALU control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT), ALUOp codes, funct constants, bit-index constants for wb/m/ex control vectors (shared with id_stage and mem stage).
- One sub-module: alu_control (ALUOp + funct -> 3-bit ctl), purely combinational. ALU, muxes, adder and EX/MEM register inline in ex_stage.

## Test plan
- lw: ex=4'b0001, m=3'b010, wb=2'b11, reg1=0x100, sign_ext=0x4, rt=8 -> next edge alu_result=0x104, zero=0, muxout=8, m=010, wb=11.
- R-type add/sub/and/or/slt: ex=4'b1100, rd=9, reg1=5, reg2=7, funct 0x20/0x22/0x24/0x25/0x2A -> 12 / 0xFFFFFFFE / 5 / 7 / 1; muxout=9. SLT with reg1=0xFFFFFFFF, reg2=1 -> 1 (signed).
- beq: ex=4'b0010, m=3'b100, reg1=reg2=3, npc=0x10000004, sign_ext=2 -> zero=1, btgt=0x1000000C; sign_ext=0xFFFFFFFF -> btgt=0x10000000.
- sw: ex=4'b0001, m=3'b001, reg1=0x200, sign_ext=0x10, reg2=0xDEADBEEF -> alu_result=0x210, rdata2=0xDEADBEEF.
- stall/flush: load lw, assert stall 3 cycles with changed inputs -> outputs unchanged; assert stall+flush -> all outputs 0 next edge.
- reset: drive rst=0 mid-stream with stall=1 -> all outputs 0 at that edge; release -> first load after one edge.
